// File: rtl/rvx_core_store_queue_if.sv
// Store-queue port bundle: execute-stage store request side and data-memory write side.
// The slave modport is the queue itself; master is the surrounding core/memory.
interface rvx_core_store_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int NBYTES = XLEN / 8;
  localparam int CNTW   = $clog2(DEPTH) + 1;

  logic              store_valid;
  logic              store_ready;
  logic [2:0]        funct3;
  logic [XLEN-1:0]   store_address;
  logic [XLEN-1:0]   rs2_data;
  logic [XLEN-1:0]   mem_address;
  logic [XLEN-1:0]   mem_write_data;
  logic [NBYTES-1:0] mem_write_strobe;
  logic              mem_write_request;
  logic              mem_write_response;
  logic              queue_empty;
  logic [CNTW-1:0]   queue_count;
  logic              misaligned_fault;

  modport slave (
    input  store_valid, funct3, store_address, rs2_data, mem_write_response,
    output store_ready, mem_address, mem_write_data, mem_write_strobe,
           mem_write_request, queue_empty, queue_count, misaligned_fault
  );

  modport master (
    output store_valid, funct3, store_address, rs2_data, mem_write_response,
    input  store_ready, mem_address, mem_write_data, mem_write_strobe,
           mem_write_request, queue_empty, queue_count, misaligned_fault
  );
endinterface

// File: rtl/rvx_core_store_queue.sv
// Store formatting and buffering queue: lane-aligns stores and drains them to data memory.
// RVX_MISALIGNED_STORE_EN: when defined, word-crossing stores split into two beats instead of faulting.
module rvx_core_store_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input logic clock,
  input logic reset_n,
  rvx_core_store_queue_if.slave sq
);
  localparam int NBYTES = XLEN / 8;
  localparam int OFFW   = $clog2(NBYTES);
  localparam int PTRW   = $clog2(DEPTH);
  localparam int CNTW   = PTRW + 1;

  localparam logic [1:0]          MAX_LG     = 2'(OFFW);
  localparam logic [OFFW:0]       SZ_ONE     = {{OFFW{1'b0}}, 1'b1};
  localparam logic [2*NBYTES-1:0] STRB_ONE   = {{(2*NBYTES-1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0]     COUNT_FULL = CNTW'(DEPTH);

  logic [XLEN-1:0]   addr_mem [DEPTH];
  logic [XLEN-1:0]   data_mem [DEPTH];
  logic [NBYTES-1:0] strb_mem [DEPTH];

  logic [PTRW-1:0] wr_ptr, rd_ptr, wr_ptr_next;
  logic [CNTW-1:0] count;

  logic                full_width;
  logic [1:0]          size_lg;
  logic [OFFW:0]       size;
  logic [OFFW-1:0]     off;
  logic [2*NBYTES-1:0] strb_base;
  logic [2*NBYTES-1:0] strobe_wide;
  logic [XLEN-1:0]     data_mask;
  logic [2*XLEN-1:0]   data_wide;
  logic                crosses;
  logic [XLEN-1:0]     base_address;
  logic [XLEN-1:0]     next_address;

  logic       ready;
  logic       drop;
  logic       handshake;
  logic       deq;
  logic [1:0] enq_n;

  always_comb begin
    full_width  = sq.funct3[2] | (sq.funct3[1:0] > MAX_LG);
    size_lg     = full_width ? MAX_LG : sq.funct3[1:0];
    size        = SZ_ONE << size_lg;
    off         = full_width ? '0 : sq.store_address[OFFW-1:0];
    strb_base   = (STRB_ONE << size) - STRB_ONE;
    strobe_wide = strb_base << off;
    data_mask   = '0;
    for (int i = 0; i < NBYTES; i++) begin
      data_mask[8*i +: 8] = {8{strb_base[i]}};
    end
    data_wide    = {{XLEN{1'b0}}, sq.rs2_data & data_mask} << {off, 3'b000};
    crosses      = |strobe_wide[2*NBYTES-1:NBYTES];
    base_address = {sq.store_address[XLEN-1:OFFW], {OFFW{1'b0}}};
    next_address = base_address + XLEN'(NBYTES);
  end

`ifdef RVX_MISALIGNED_STORE_EN
  // Two free slots are reserved so a split store can always land both beats in one edge.
  assign ready = (count <= CNTW'(DEPTH - 2));
  assign drop  = 1'b0;
  assign sq.misaligned_fault = 1'b0;
`else
  logic misaligned;
  logic fault_q;

  assign misaligned = |({1'b0, off} & (size - SZ_ONE));
  assign ready      = (count != COUNT_FULL);
  assign drop       = misaligned;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) fault_q <= 1'b0;
    else          fault_q <= handshake & misaligned;
  end
  assign sq.misaligned_fault = fault_q;
`endif

  assign handshake   = sq.store_valid & ready;
  assign deq         = sq.mem_write_request & sq.mem_write_response;
  assign enq_n       = (handshake && !drop) ? (crosses ? 2'd2 : 2'd1) : 2'd0;
  assign wr_ptr_next = wr_ptr + PTRW'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
        strb_mem[i] <= '0;
      end
    end else begin
      if (enq_n != 2'd0) begin
        addr_mem[wr_ptr] <= base_address;
        data_mem[wr_ptr] <= data_wide[XLEN-1:0];
        strb_mem[wr_ptr] <= strobe_wide[NBYTES-1:0];
        // High beat goes in the following slot so it always drains after the low beat.
        if (enq_n == 2'd2) begin
          addr_mem[wr_ptr_next] <= next_address;
          data_mem[wr_ptr_next] <= data_wide[2*XLEN-1:XLEN];
          strb_mem[wr_ptr_next] <= strobe_wide[2*NBYTES-1:NBYTES];
        end
        wr_ptr <= wr_ptr + PTRW'(enq_n);
      end
      if (deq) rd_ptr <= rd_ptr + PTRW'(1);
      count <= count + CNTW'(enq_n) - CNTW'(deq);
    end
  end

  assign sq.store_ready       = ready;
  assign sq.queue_count       = count;
  assign sq.queue_empty       = (count == '0);
  assign sq.mem_write_request = (count != '0);
  assign sq.mem_address       = addr_mem[rd_ptr];
  assign sq.mem_write_data    = data_mem[rd_ptr];
  assign sq.mem_write_strobe  = strb_mem[rd_ptr];
endmodule

// File: doc/rvx_core_store_queue.md
# rvx_core_store_queue

Parametrised store formatting and buffering unit for the RVX core write path. Accepts store operations (address, rs2 data, funct3) from the execute stage, lane-aligns data and byte strobes for an XLEN-wide data bus, and holds them in a DEPTH-entry FIFO. It drains the FIFO to the data memory port through a request/response handshake, so the pipeline does not stall on slow writes. Optionally splits stores that cross a bus-word boundary into two bus beats.

## Interface
- XLEN, 32: data and address width; legal values 32 or 64. NBYTES = XLEN/8.
- DEPTH, 4: FIFO entries; power of two, ≥2.

- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- store_valid  in  1  store offered this cycle.
- store_ready  out  1  queue can accept; a store transfers when store_valid && store_ready.
- funct3  in  3  RISC-V store funct3 (SB/SH/SW/SD).
- store_address  in  XLEN  byte address of the store.
- rs2_data  in  XLEN  store data, right-justified.
- mem_address  out  XLEN  head-entry address, aligned to NBYTES.
- mem_write_data  out  XLEN  head-entry lane-aligned data.
- mem_write_strobe  out  NBYTES  head-entry byte enables.
- mem_write_request  out  1  head entry valid.
- mem_write_response  in  1  memory accepts the head entry this cycle.
- queue_empty  out  1  no entries held.
- queue_count  out  $clog2(DEPTH)+1  entries held.
- misaligned_fault  out  1  one-cycle pulse: the accepted store was dropped as misaligned.

## Operation
- Size: SB=1, SH=2, SW=4, SD=8 bytes. If funct3[2]=1 or size > NBYTES, treat the store as a full-width store (NBYTES).
- Offset: off = store_address[log2(NBYTES)-1:0]. Byte i of rs2_data goes to lane off+i, and the strobe bit is set for that lane. Unused lanes carry data 0 and strobe 0.
- Entry: {store_address with low bits cleared, data, strobe}.
- Enqueue occurs on the handshake; dequeue occurs on mem_write_request && mem_write_response. Both can happen in the same cycle, in which case the count is unchanged.
- Pointers wrap modulo DEPTH. Head outputs are driven directly from head-entry storage.
- mem_write_request = !queue_empty. Address, data and strobe stay stable while request is high and response is low.
- Full-width stores are never misaligned, because off is forced to 0 for them.

## Timing
- Reset (asynchronous assert, synchronous deassert edge at the next clock):
  - pointers and count are 0; queue_empty=1.
  - mem_write_request=0 and misaligned_fault=0.
  - storage is cleared, so mem_address, mem_write_data and mem_write_strobe are 0.
- Reset mid-operation discards all entries. No beat is reissued.
- Latency: a store accepted at edge N appears on the mem_* outputs after edge N when the queue was empty. Throughput is one entry per cycle.
- store_ready is combinational from the count only, never from store_valid or funct3. It is high when free slots ≥ 2 (macro on) or ≥ 1 (macro off).
- A dequeue in the current cycle does not raise store_ready in the same cycle.
- misaligned_fault is registered: it pulses in the cycle after the dropping handshake.

## Configuration
- RVX_MISALIGNED_STORE_EN defined:
  - A store whose bytes all fit inside one bus word is enqueued as one entry, even if it is not naturally aligned.
  - A store where off+size > NBYTES is split into two entries written in the same edge.
    - Low beat: aligned address; lanes off..NBYTES-1 hold the low bytes.
    - High beat: aligned address+NBYTES; lanes 0..(off+size-NBYTES-1) hold the remaining bytes.
  - The high beat always leaves after the low beat. misaligned_fault is tied to 0.
- Undefined:
  - Any store with off not a multiple of size is accepted but not enqueued, and misaligned_fault pulses.
  - store_ready requires only 1 free slot.

## Test plan
- XLEN=32: SB at address 0x1003, rs2_data 0xAABBCCDD, response held 1 -> one beat: address 0x1000, data 0xDD000000, strobe 4'b1000, request high for one cycle.
- XLEN=32, macro on: SW at 0x2002, data 0x11223344 -> two beats.
  - Beat 1: 0x2000, data 0x33440000, strobe 1100.
  - Beat 2: 0x2004, data 0x00001122, strobe 0011.
  - queue_count goes 0 -> 2.
- XLEN=32, macro off: SH at 0x3001 -> nothing enqueued; misaligned_fault=1 for exactly one cycle; queue_empty stays 1.
- DEPTH=4, response held 0, back-to-back SB stores:
  - macro off: store_ready falls when count=4.
  - macro on: store_ready falls when count=3.
  - Then response=1 -> entries drain in FIFO order and the count decrements once per cycle.
- Simultaneous enqueue and dequeue at count=2 for 6 cycles -> count stays 2, pointers wrap, data order is preserved.
- XLEN=64: SD at 0x4000 data 0x0123456789ABCDEF -> strobe 8'hFF. Then assert reset_n=0 mid-drain -> all outputs are 0 immediately and queue_empty=1.
